// File: rtl/halut_pkg.sv
// ============================================================================
// halut_pkg: shared widths, defaults and decoder state encoding for HALUT
// Rev 1.0
// ============================================================================
`default_nettype none

package halut_pkg;

    localparam int K             = 16;
    localparam int C             = 32;
    localparam int DataTypeWidth = 16;
    localparam int AccWidth      = 24;
    localparam int CodeWidth     = $clog2(K);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = StIdle,
        ST_ACCUM = StAccum,
        ST_HOLD  = StHold
    } state_e;

    // Index width that never collapses to zero bits for single-entry dimensions.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/halut_decoder_mc_if.sv
// ============================================================================
// halut_decoder_mc_if: LUT write, code stream and result stream bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface halut_decoder_mc_if #(
    parameter int K             = halut_pkg::K,
    parameter int C             = halut_pkg::C,
    parameter int M             = 2,
    parameter int DataTypeWidth = halut_pkg::DataTypeWidth,
    parameter int AccWidth      = halut_pkg::AccWidth
);
    import halut_pkg::*;

    localparam int CIdxW = idx_width(C);
    localparam int KIdxW = idx_width(K);
    localparam int MIdxW = idx_width(M);

    logic                     lut_we_i;
    logic [CIdxW-1:0]         lut_c_i;
    logic [KIdxW-1:0]         lut_k_i;
    logic [MIdxW-1:0]         lut_m_i;
    logic [DataTypeWidth-1:0] lut_wdata_i;
    logic [$clog2(C):0]       num_c_i;
    logic                     code_valid_i;
    logic                     code_ready_o;
    logic [KIdxW-1:0]         code_i;
    logic                     res_valid_o;
    logic                     res_ready_i;
    logic [M*AccWidth-1:0]    res_o;
    logic                     ovf_o;
    logic                     busy_o;

    modport master (
        output lut_we_i, lut_c_i, lut_k_i, lut_m_i, lut_wdata_i, num_c_i,
        output code_valid_i, code_i, res_ready_i,
        input  code_ready_o, res_valid_o, res_o, ovf_o, busy_o
    );

    modport slave (
        input  lut_we_i, lut_c_i, lut_k_i, lut_m_i, lut_wdata_i, num_c_i,
        input  code_valid_i, code_i, res_ready_i,
        output code_ready_o, res_valid_o, res_o, ovf_o, busy_o
    );

endinterface

`default_nettype wire

// File: rtl/halut_sat_add.sv
// ============================================================================
// halut_sat_add: signed adder with overflow flag, clamping or wrapping result
// Rev 1.0
// ============================================================================
`default_nettype none

module halut_sat_add #(
    parameter int Width    = halut_pkg::AccWidth,
    parameter bit Saturate = 1'b1
) (
    input  logic signed [Width-1:0] a,
    input  logic signed [Width-1:0] b,
    output logic signed [Width-1:0] sum,
    output logic                    ovf
);

    logic signed [Width-1:0] raw;

    assign raw = a + b;
    // Overflow only when both operands share a sign the result does not.
    assign ovf = (a[Width-1] == b[Width-1]) && (raw[Width-1] != a[Width-1]);

    generate
        if (Saturate) begin : g_sat
            localparam logic signed [Width-1:0] MaxVal = {1'b0, {(Width-1){1'b1}}};
            localparam logic signed [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};
            assign sum = ovf ? (a[Width-1] ? MinVal : MaxVal) : raw;
        end else begin : g_wrap
            assign sum = raw;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/halut_decoder_mc.sv
// ============================================================================
// halut_decoder_mc: per-row LUT lookup and M-lane accumulation of codebook hits
// Rev 1.0
// ============================================================================
`default_nettype none

module halut_decoder_mc #(
    parameter int K             = halut_pkg::K,
    parameter int C             = halut_pkg::C,
    parameter int M             = 2,
    parameter int DataTypeWidth = halut_pkg::DataTypeWidth,
    parameter int AccWidth      = halut_pkg::AccWidth,
    parameter bit Saturate      = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    halut_decoder_mc_if.slave bus
);
    import halut_pkg::*;

    localparam int              CntW  = idx_width(C);
    localparam int              NcW   = $clog2(C) + 1;
    localparam logic [NcW-1:0]  NcMax = NcW'(C);

    typedef logic signed [DataTypeWidth-1:0] entry_t;
    typedef logic signed [AccWidth-1:0]      acc_t;

    entry_t                lut [C][K][M];
    state_e                state;
    state_e                state_nxt;
    logic [CntW-1:0]       cnt;
    logic [NcW-1:0]        nc_q;
    logic [NcW-1:0]        nc_in;
    logic [NcW-1:0]        nc_eff;
    acc_t                  acc [M];
    acc_t                  sum [M];
    logic [M-1:0]          lane_ovf;
    logic [M*AccWidth-1:0] sum_flat;
    logic [M*AccWidth-1:0] res_q;
    logic                  ovf_row;
    logic                  ovf_q;
    logic                  ovf_nxt;
    logic                  ready_q;
    logic                  accept;
    logic                  first;
    logic                  last;
    logic                  cnt_zero;

    assign accept   = bus.code_valid_i & ready_q;
    assign first    = (state == ST_IDLE);
    assign cnt_zero = (cnt == '0);
    assign nc_in    = ((bus.num_c_i == '0) || (bus.num_c_i > NcMax)) ? NcMax : bus.num_c_i;
    // The row length is only taken from the port on the opening code.
    assign nc_eff   = first ? nc_in : nc_q;
    assign last     = (NcW'(cnt) == (nc_eff - NcW'(1)));
    assign ovf_nxt  = (cnt_zero ? 1'b0 : ovf_row) | (|lane_ovf);

    generate
        for (genvar m = 0; m < M; m++) begin : g_lane
            entry_t entry;
            acc_t   addend;
            acc_t   base;

            assign entry  = lut[cnt][bus.code_i][m];
            assign addend = acc_t'(entry);
            assign base   = cnt_zero ? '0 : acc[m];

            halut_sat_add #(
                .Width    (AccWidth),
                .Saturate (Saturate)
            ) u_add (
                .a   (base),
                .b   (addend),
                .sum (sum[m]),
                .ovf (lane_ovf[m])
            );

            assign sum_flat[m*AccWidth +: AccWidth] = sum[m];
        end
    endgenerate

    // Reads above see the pre-write contents, so a same-cycle write is not forwarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < C; c++) begin
                for (int k = 0; k < K; k++) begin
                    for (int m = 0; m < M; m++) begin
                        lut[c][k][m] <= '0;
                    end
                end
            end
        end else if (bus.lut_we_i) begin
            lut[bus.lut_c_i][bus.lut_k_i][bus.lut_m_i] <= bus.lut_wdata_i;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    state_nxt = last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (bus.res_ready_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            nc_q    <= '0;
            ovf_row <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != ST_HOLD);
            if (accept) begin
                cnt     <= last ? '0 : (cnt + CntW'(1));
                ovf_row <= ovf_nxt;
                if (first) begin
                    nc_q <= nc_in;
                end
                if (last) begin
                    res_q <= sum_flat;
                    ovf_q <= ovf_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int m = 0; m < M; m++) begin
                acc[m] <= '0;
            end
        end else if (accept) begin
            for (int m = 0; m < M; m++) begin
                acc[m] <= sum[m];
            end
        end
    end

    assign bus.code_ready_o = ready_q;
    assign bus.res_valid_o  = (state == ST_HOLD);
    assign bus.res_o        = res_q;
    assign bus.ovf_o        = ovf_q;
    assign bus.busy_o       = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_halut_decoder_mc.sv
// ============================================================================
// tb_halut_decoder_mc: three decoder variants fed one stimulus, checked against
// an arithmetic row model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_halut_decoder_mc;

    localparam int K = 16;
    localparam int C = 32;
    localparam int M = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        lut_we;
    logic [4:0]  lut_c;
    logic [3:0]  lut_k;
    logic [0:0]  lut_m;
    logic [15:0] lut_wdata;
    logic [5:0]  num_c;
    logic        code_valid;
    logic [3:0]  code;
    logic        res_ready;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     lut_ref [C][K][M];
    longint exp_lane [3][M];
    bit     exp_ovf [3];

    halut_decoder_mc_if                  bus_main ();
    halut_decoder_mc_if #(.AccWidth(17)) bus_s17 ();
    halut_decoder_mc_if #(.AccWidth(17)) bus_w17 ();

    assign bus_main.lut_we_i = lut_we;  assign bus_s17.lut_we_i = lut_we;  assign bus_w17.lut_we_i = lut_we;
    assign bus_main.lut_c_i = lut_c;    assign bus_s17.lut_c_i = lut_c;    assign bus_w17.lut_c_i = lut_c;
    assign bus_main.lut_k_i = lut_k;    assign bus_s17.lut_k_i = lut_k;    assign bus_w17.lut_k_i = lut_k;
    assign bus_main.lut_m_i = lut_m;    assign bus_s17.lut_m_i = lut_m;    assign bus_w17.lut_m_i = lut_m;
    assign bus_main.lut_wdata_i = lut_wdata; assign bus_s17.lut_wdata_i = lut_wdata; assign bus_w17.lut_wdata_i = lut_wdata;
    assign bus_main.num_c_i = num_c;    assign bus_s17.num_c_i = num_c;    assign bus_w17.num_c_i = num_c;
    assign bus_main.code_valid_i = code_valid; assign bus_s17.code_valid_i = code_valid; assign bus_w17.code_valid_i = code_valid;
    assign bus_main.code_i = code;      assign bus_s17.code_i = code;      assign bus_w17.code_i = code;
    assign bus_main.res_ready_i = res_ready; assign bus_s17.res_ready_i = res_ready; assign bus_w17.res_ready_i = res_ready;

    halut_decoder_mc dut_main (.clk_i(clk), .rst_ni(rst_n), .bus(bus_main.slave));
    halut_decoder_mc #(.AccWidth(17), .Saturate(1'b1)) dut_s17 (.clk_i(clk), .rst_ni(rst_n), .bus(bus_s17.slave));
    halut_decoder_mc #(.AccWidth(17), .Saturate(1'b0)) dut_w17 (.clk_i(clk), .rst_ni(rst_n), .bus(bus_w17.slave));

    always #5 clk = ~clk;

    function automatic int acc_w(input int d);
        return (d == 0) ? 24 : 17;
    endfunction

    function automatic logic [63:0] trunc(input longint v, input int w);
        return 64'(v) & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] lane_obs(input int d, input int m);
        case (d)
            0:       return 64'(bus_main.res_o[m*24 +: 24]);
            1:       return 64'(bus_s17.res_o[m*17 +: 17]);
            default: return 64'(bus_w17.res_o[m*17 +: 17]);
        endcase
    endfunction

    function automatic logic ovf_obs(input int d);
        case (d)
            0:       return bus_main.ovf_o;
            1:       return bus_s17.ovf_o;
            default: return bus_w17.ovf_o;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Row model: first hit loads, later hits add with clamp (d<2) or wrap (d==2).
    task automatic compute_expected(input int q[$]);
        for (int d = 0; d < 3; d++) begin
            longint w_max = (longint'(1) << (acc_w(d) - 1)) - 1;
            longint w_min = -(longint'(1) << (acc_w(d) - 1));
            exp_ovf[d] = 1'b0;
            for (int m = 0; m < M; m++) begin
                longint a = 0;
                for (int i = 0; i < q.size(); i++) begin
                    longint s = a + longint'(lut_ref[i][q[i]][m]);
                    if (i == 0) s = longint'(lut_ref[i][q[i]][m]);
                    if (s > w_max || s < w_min) begin
                        exp_ovf[d] = 1'b1;
                        if (d != 2) s = (s > w_max) ? w_max : w_min;
                        else        s = (s > w_max) ? s - (longint'(1) << acc_w(d)) : s + (longint'(1) << acc_w(d));
                    end
                    a = s;
                end
                exp_lane[d][m] = a;
            end
        end
    endtask

    task automatic check_results(input string tag);
        for (int d = 0; d < 3; d++) begin
            for (int m = 0; m < M; m++) begin
                check($sformatf("%s dut%0d lane%0d", tag, d, m), lane_obs(d, m), trunc(exp_lane[d][m], acc_w(d)));
            end
            check($sformatf("%s dut%0d ovf", tag, d), 64'(ovf_obs(d)), 64'(exp_ovf[d]));
        end
    endtask

    task automatic write_lut(input int c, input int k, input int m, input int val);
        logic signed [15:0] v16;
        v16       = 16'(val);
        lut_we    = 1'b1;
        lut_c     = 5'(c);
        lut_k     = 4'(k);
        lut_m     = 1'(m);
        lut_wdata = v16;
        @(negedge clk);
        lut_we    = 1'b0;
        lut_ref[c][k][m] = int'(v16);
    endtask

    task automatic fill_lut(input int mode);
        for (int c = 0; c < C; c++)
            for (int k = 0; k < K; k++)
                for (int m = 0; m < M; m++)
                    write_lut(c, k, m, (mode == 0) ? (c + k + m) :
                                       (mode == 1) ? 32'h7FFF : int'($urandom_range(0, 65535)));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, " rst valid"}, 64'(bus_main.res_valid_o), 64'd0);
        check({tag, " rst ready"}, 64'(bus_main.code_ready_o), 64'd0);
        check({tag, " rst busy"},  64'(bus_main.busy_o), 64'd0);
        check({tag, " rst ovf"},   64'(bus_main.ovf_o), 64'd0);
        check({tag, " rst res"},   64'(bus_main.res_o), 64'd0);
        check({tag, " rst s17 valid"}, 64'(bus_s17.res_valid_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < C; c++)
            for (int k = 0; k < K; k++)
                for (int m = 0; m < M; m++)
                    lut_ref[c][k][m] = 0;
        @(negedge clk);
        check({tag, " post-rst ready"}, 64'(bus_main.code_ready_o), 64'd1);
        check({tag, " post-rst busy"},  64'(bus_main.busy_o), 64'd0);
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, " after-ack valid"}, 64'(bus_main.res_valid_o), 64'd0);
        check({tag, " after-ack ready"}, 64'(bus_main.code_ready_o), 64'd1);
        check({tag, " after-ack busy"},  64'(bus_main.busy_o), 64'd0);
    endtask

    // Streams one row; wr_at >= 0 writes LUT[wr_at][code][0] in the cycle that code is used.
    task automatic run_row(input string tag, input int q[$], input int nc, input int hold,
                           input bit rel, input int wr_at, input int wr_val, input bit bubbles);
        compute_expected(q);
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0 && bubbles) begin
                repeat ($urandom_range(0, 2)) begin
                    code_valid = 1'b0;
                    code       = 4'($urandom);
                    num_c      = 6'($urandom);
                    @(negedge clk);
                end
            end
            check($sformatf("%s ready before code%0d", tag, i), 64'(bus_main.code_ready_o), 64'd1);
            code_valid = 1'b1;
            code       = 4'(q[i]);
            num_c      = (i == 0) ? 6'(nc) : 6'($urandom_range(0, 63));
            if (i == wr_at) begin
                write_lut(i, q[i], 0, wr_val);
            end else begin
                @(negedge clk);
            end
        end
        code_valid = 1'b0;
        check({tag, " valid"}, 64'(bus_main.res_valid_o), 64'd1);
        check({tag, " ready in hold"}, 64'(bus_main.code_ready_o), 64'd0);
        check({tag, " busy in hold"}, 64'(bus_main.busy_o), 64'd1);
        check_results(tag);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check($sformatf("%s hold%0d valid", tag, h), 64'(bus_main.res_valid_o), 64'd1);
            check($sformatf("%s hold%0d ready", tag, h), 64'(bus_main.code_ready_o), 64'd0);
            check_results($sformatf("%s hold%0d", tag, h));
        end
        if (rel) release_result(tag);
    endtask

    initial begin
        int q[$];
        int nc;
        int eff;

        lut_we = 1'b0; lut_c = '0; lut_k = '0; lut_m = '0; lut_wdata = '0;
        num_c = '0; code_valid = 1'b0; code = '0; res_ready = 1'b0;
        @(negedge clk);
        do_reset("init");

        fill_lut(0);
        q = '{1, 2, 3, 4};
        run_row("basic", q, 4, 5, 1'b0, -1, 0, 1'b0);
        check("basic lane0 const", lane_obs(0, 0), 64'd16);
        check("basic lane1 const", lane_obs(0, 1), 64'd20);
        release_result("basic");

        q = '{7};
        run_row("nc1", q, 1, 1, 1'b1, -1, 0, 1'b0);

        q = {};
        for (int i = 0; i < 32; i++) q.push_back(int'($urandom_range(0, 15)));
        run_row("nc0", q, 0, 0, 1'b1, -1, 0, 1'b1);
        run_row("nc45", q, 45, 2, 1'b1, -1, 0, 1'b1);

        q = '{3, 5, 9, 2};
        run_row("samecyc", q, 4, 0, 1'b1, 1, 1000, 1'b0);
        q = '{0, 5};
        run_row("newval", q, 2, 0, 1'b1, -1, 0, 1'b0);

        fill_lut(1);
        q = '{1, 6, 11, 15};
        run_row("ovf", q, 4, 0, 1'b0, -1, 0, 1'b0);
        check("ovf main lane0 const", lane_obs(0, 0), 64'd131068);
        check("ovf s17 lane0 const",  lane_obs(1, 0), 64'h0FFFF);
        check("ovf w17 lane0 const",  lane_obs(2, 0), 64'h1FFFC);
        check("ovf s17 flag const",   64'(ovf_obs(1)), 64'd1);
        release_result("ovf");
        q = '{2};
        run_row("ovfclr", q, 1, 0, 1'b1, -1, 0, 1'b0);

        fill_lut(2);
        for (int r = 0; r < 6; r++) begin
            nc  = int'($urandom_range(0, 63));
            eff = (nc == 0 || nc > C) ? C : nc;
            q = {};
            for (int i = 0; i < eff; i++) q.push_back(int'($urandom_range(0, 15)));
            run_row($sformatf("rand%0d", r), q, nc, int'($urandom_range(0, 3)), 1'b1, -1, 0, 1'b1);
        end

        code_valid = 1'b1; num_c = 6'd4; code = 4'd3;
        @(negedge clk);
        code = 4'd8;
        @(negedge clk);
        code_valid = 1'b0;
        do_reset("midrow");
        fill_lut(2);
        q = '{4, 9, 1, 12};
        run_row("postrst", q, 4, 0, 1'b1, -1, 0, 1'b0);

        run_row("holdrst", q, 4, 1, 1'b0, -1, 0, 1'b0);
        do_reset("inhold");
        check("inhold no result", 64'(bus_main.res_valid_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
